stopwatch_bcd: RTL and testbench
================================

# stopwatch_bcd

Timekeeping stage fed by the clock divider's slow square-wave output. It detects rising edges of that signal in the system clock domain and advances a four-digit BCD MM:SS count. The count is controlled by start, stop and clear pulses. Its digit outputs feed the seven-segment display driver.

## Interface
- `TICKS_PER_INC`, 1, number of `tick_in` rising edges per one-second increment; legal range 1..65535.
- `WRAP`, 1, behaviour at 99:59:
  - 1: roll over to 00:00.
  - 0: saturate at 99:59.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: reset; one clock; reset is synchronous and active-high.
- `tick_in` input 1: divided square wave, already in the `clk` domain.
- `start` input 1: single-cycle pulse; begin or resume counting.
- `stop` input 1: single-cycle pulse; pause counting.
- `clear` input 1: single-cycle pulse; zero the count and return to IDLE.
- `sec_ones` output 4: BCD seconds units, 0..9.
- `sec_tens` output 4: BCD seconds tens, 0..5.
- `min_ones` output 4: BCD minutes units, 0..9.
- `min_tens` output 4: BCD minutes tens, 0..9.
- `running` output 1: high while in RUN.
- `overflow` output 1: sticky flag; set when 99:59 is reached with a further increment pending.

## Operation
- Edge detect:
  - `tick_q` is a register loaded with `tick_in` every cycle.
  - `edge = tick_in & ~tick_q`.
- State machine with states IDLE, RUN, PAUSE. Control priority within one cycle: `clear` > `stop` > `start`.
  - Any state + `clear` -> IDLE. Digits, prescaler and `overflow` all go to 0.
  - IDLE or PAUSE + `start` -> RUN.
  - RUN + `stop` -> PAUSE.
  - All other cases: hold state. `start` in RUN and `stop` in IDLE/PAUSE are ignored.
- Increment qualifier `inc_en`: state register == RUN, `edge` = 1, `clear` = 0, `stop` = 0. An edge in the same cycle as `start` is not counted.
- Prescaler (16-bit):
  - On `inc_en`: if prescaler == `TICKS_PER_INC`-1, it goes to 0 and a digit increment fires; otherwise it increments by 1.
  - The prescaler holds in PAUSE and IDLE.
- Digit increment is a ripple-carry BCD chain:
  - `sec_ones` 9 -> 0 carries into `sec_tens`.
  - `sec_tens` 5 -> 0 carries into `min_ones`.
  - `min_ones` 9 -> 0 carries into `min_tens`.
- Terminal value 99:59 with a digit increment firing:
  - `WRAP`=1: all digits go to 0 and `overflow` is set to 1. State stays RUN.
  - `WRAP`=0: digits hold at 99:59 and `overflow` is set to 1. State stays RUN; further increments change nothing.
- `overflow` is cleared only by `clear` or `rst`.
- Digits never take non-BCD values. `sec_tens` never exceeds 5.

## Timing
- Reset values: state IDLE, `tick_q` = 0, prescaler = 0, all digits 0, `running` = 0, `overflow` = 0.
- Because `tick_q` resets to 0, an edge is detected if `tick_in` = 1 in the first cycle after reset. It is not counted, since the state is IDLE.
- Latency from `tick_in` rising (sampled in cycle N) to the digit change: outputs update at the clock edge ending cycle N and are visible in cycle N+1.
- `running` is a registered output. It rises the cycle after `start` and falls the cycle after `stop` or `clear`.
- Control-pulse latency: one cycle for all controls. `clear` zeroes the digits in the cycle after it is asserted.
- A `tick_in` held high produces exactly one edge. Edges closer than 2 cycles cannot occur by construction; none are required to be counted.
- `rst` asserted mid-count returns every register to its reset value on the next edge, regardless of other inputs.
- `TICKS_PER_INC`=1 means every qualified edge increments the digits.

## Test plan
- Reset, then `start`, then 10 `tick_in` edges (`TICKS_PER_INC`=1) -> displays 00:10 and `running`=1. Each digit change occurs exactly 1 cycle after the edge.
- Preload to 00:59 via 59 edges, then one more edge -> 01:00. Continue to 09:59, then one edge -> 10:00.
- `WRAP`=1: count to 99:59, then one edge -> 00:00 with `overflow`=1. `WRAP`=0: the same sequence -> holds at 99:59 with `overflow`=1, and 3 more edges leave the display at 99:59.
- Mid-count `stop` at 00:07, then 5 edges -> stays 00:07 and `running`=0. Then `start` and 2 edges -> 00:09.
- Same-cycle events:
  - `start`+edge: edge not counted.
  - `stop`+edge: not counted.
  - `clear`+`start`+edge: -> IDLE, 00:00.
  - `rst` asserted at 00:42 with `tick_in` high: -> all outputs 0 next cycle.
- `TICKS_PER_INC`=4, run 10 edges -> 00:02 with prescaler at 2. `stop`, then `start`, then 2 edges -> 00:03.

Source files
------------

// File: rtl/stopwatch_bcd.sv
// -----------------------------------------------------------------------------
// stopwatch_bcd
//
// MM:SS stopwatch for the seven-segment display path. Rising edges of the
// divided square wave on tick_in are detected in the clk domain. Every
// TICKS_PER_INC qualified edges, the four-digit BCD count advances by one
// second. start/stop/clear pulses drive a small run/pause state machine.
//
// Parameters
//   TICKS_PER_INC  tick_in rising edges per one-second increment (1..65535)
//   WRAP           1: 99:59 rolls over to 00:00, 0: 99:59 saturates
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   tick_in   in   divided square wave, already synchronous to clk
//   start     in   pulse: begin or resume counting
//   stop      in   pulse: pause counting
//   clear     in   pulse: zero the count and return to idle
//   sec_ones  out  BCD seconds units (0..9)
//   sec_tens  out  BCD seconds tens  (0..5)
//   min_ones  out  BCD minutes units (0..9)
//   min_tens  out  BCD minutes tens  (0..9)
//   running   out  registered, high while in RUN
//   overflow  out  sticky, set when an increment fires at 99:59
//
// State  | meaning
// -------+--------------------------------------------------------------
// IDLE   | cleared or just reset; edges ignored, prescaler held
// RUN    | qualified edges advance prescaler and digits
// PAUSE  | count frozen; start resumes without losing prescaler phase
// -----------------------------------------------------------------------------
module stopwatch_bcd #(
  parameter int unsigned TICKS_PER_INC = 1,
  parameter bit          WRAP          = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       overflow
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  // Terminal prescaler value; TICKS_PER_INC = 1 gives 0, so every
  // qualified edge fires a digit increment.
  localparam logic [15:0] PRESC_LAST = 16'(TICKS_PER_INC - 1);

  logic [1:0]  state_q, state_d;
  logic        tick_q;
  logic        tick_edge;
  logic        inc_en;
  logic [15:0] presc_q, presc_d;
  logic        digit_fire;
  logic [3:0]  sec_ones_q, sec_ones_d;
  logic [3:0]  sec_tens_q, sec_tens_d;
  logic [3:0]  min_ones_q, min_ones_d;
  logic [3:0]  min_tens_q, min_tens_d;
  logic        at_max;
  logic        overflow_q, overflow_d;
  logic        running_q;

  // ---------------------------------------------------------------------------
  // Edge detect
  // ---------------------------------------------------------------------------
  assign tick_edge = tick_in & ~tick_q;

  // Edges coinciding with clear or stop are dropped, and the state register
  // (not the next state) gates counting, so an edge arriving with start is
  // also dropped.
  assign inc_en = (state_q == ST_RUN) & tick_edge & ~clear & ~stop;

  // ---------------------------------------------------------------------------
  // State machine, priority clear > stop > start
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (stop) begin
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSE;
      end
    end else if (start) begin
      if (state_q != ST_RUN) begin
        state_d = ST_RUN;
      end
    end
    // Unused encoding falls back to idle.
    if (state_d != ST_IDLE && state_d != ST_RUN && state_d != ST_PAUSE) begin
      state_d = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  always_comb begin
    presc_d    = presc_q;
    digit_fire = 1'b0;
    if (clear) begin
      presc_d = 16'd0;
    end else if (inc_en) begin
      if (presc_q >= PRESC_LAST) begin
        presc_d    = 16'd0;
        digit_fire = 1'b1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // BCD ripple chain
  // ---------------------------------------------------------------------------
  assign at_max = (min_tens_q == 4'd9) && (min_ones_q == 4'd9) &&
                  (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);

  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    overflow_d = overflow_q;
    if (clear) begin
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
      overflow_d = 1'b0;
    end else if (digit_fire) begin
      if (at_max) begin
        overflow_d = 1'b1;
        if (WRAP) begin
          sec_ones_d = 4'd0;
          sec_tens_d = 4'd0;
          min_ones_d = 4'd0;
          min_tens_d = 4'd0;
        end
      end else if (sec_ones_q < 4'd9) begin
        sec_ones_d = sec_ones_q + 4'd1;
      end else begin
        sec_ones_d = 4'd0;
        if (sec_tens_q < 4'd5) begin
          sec_tens_d = sec_tens_q + 4'd1;
        end else begin
          sec_tens_d = 4'd0;
          if (min_ones_q < 4'd9) begin
            min_ones_d = min_ones_q + 4'd1;
          end else begin
            min_ones_d = 4'd0;
            // at_max excluded 9 here, so this stays within 0..9.
            min_tens_d = min_tens_q + 4'd1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_q     <= 1'b0;
      presc_q    <= 16'd0;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      overflow_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_in;
      presc_q    <= presc_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      overflow_q <= overflow_d;
      running_q  <= (state_d == ST_RUN);
    end
  end

  assign sec_ones = sec_ones_q;
  assign sec_tens = sec_tens_q;
  assign min_ones = min_ones_q;
  assign min_tens = min_tens_q;
  assign running  = running_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_bcd
//
// Three stopwatch instances share one stimulus stream:
//   dut 0: TICKS_PER_INC=1, WRAP=1
//   dut 1: TICKS_PER_INC=1, WRAP=0
//   dut 2: TICKS_PER_INC=4, WRAP=1
// A reference model keeps the count as a plain number of seconds and derives
// the BCD digits by division. Expected outputs are queued when each cycle's
// inputs are driven, and popped and compared after the clock edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_bcd;

  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_RUN   = 2'd1;
  localparam logic [1:0] M_PAUSE = 2'd2;

  logic clk = 1'b0;
  logic rst, tick_in, start, stop, clear;

  logic [3:0] so0, st0, mo0, mt0, so1, st1, mo1, mt1, so2, st2, mo2, mt2;
  logic       run0, ovf0, run1, ovf1, run2, ovf2;

  logic [17:0] obs_v [3];
  assign obs_v[0] = {mt0, mo0, st0, so0, run0, ovf0};
  assign obs_v[1] = {mt1, mo1, st1, so1, run1, ovf1};
  assign obs_v[2] = {mt2, mo2, st2, so2, run2, ovf2};

  always #5 clk = ~clk;

  stopwatch_bcd #(.TICKS_PER_INC(1), .WRAP(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop),
    .clear(clear), .sec_ones(so0), .sec_tens(st0), .min_ones(mo0),
    .min_tens(mt0), .running(run0), .overflow(ovf0));

  stopwatch_bcd #(.TICKS_PER_INC(1), .WRAP(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop),
    .clear(clear), .sec_ones(so1), .sec_tens(st1), .min_ones(mo1),
    .min_tens(mt1), .running(run1), .overflow(ovf1));

  stopwatch_bcd #(.TICKS_PER_INC(4), .WRAP(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop),
    .clear(clear), .sec_ones(so2), .sec_tens(st2), .min_ones(mo2),
    .min_tens(mt2), .running(run2), .overflow(ovf2));

  // Reference model state
  int          cfg_ticks [3] = '{1, 1, 4};
  bit          cfg_wrap  [3] = '{1'b1, 1'b0, 1'b1};
  int          m_secs    [3];
  int          m_presc   [3];
  logic        m_ovf     [3];
  logic [1:0]  m_state   [3];
  logic        m_tickq;

  logic [17:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [17:0] model_pack(input int i);
    int mins, secs;
    mins = m_secs[i] / 60;
    secs = m_secs[i] % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
            (m_state[i] == M_RUN), m_ovf[i]};
  endfunction

  // Advance the model across one clock edge given this cycle's inputs.
  task automatic model_step(input logic r, input logic t, input logic sa,
                            input logic so, input logic c);
    logic ed;
    ed = t & ~m_tickq;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_secs[i] = 0; m_presc[i] = 0; m_ovf[i] = 1'b0; m_state[i] = M_IDLE;
      end else if (c) begin
        m_secs[i] = 0; m_presc[i] = 0; m_ovf[i] = 1'b0; m_state[i] = M_IDLE;
      end else begin
        if (m_state[i] == M_RUN && ed && !so) begin
          m_presc[i]++;
          if (m_presc[i] == cfg_ticks[i]) begin
            m_presc[i] = 0;
            if (m_secs[i] == 5999) begin
              m_ovf[i] = 1'b1;
              m_secs[i] = cfg_wrap[i] ? 0 : 5999;
            end else begin
              m_secs[i]++;
            end
          end
        end
        if (so) begin
          if (m_state[i] == M_RUN) m_state[i] = M_PAUSE;
        end else if (sa) begin
          m_state[i] = M_RUN;
        end
      end
    end
    m_tickq = r ? 1'b0 : t;
  endtask

  // One clock cycle: drive inputs, queue the expected outputs, clock, compare.
  task automatic step(input logic r, input logic t, input logic sa,
                      input logic so, input logic c, input string tag);
    logic [17:0] e;
    rst = r; tick_in = t; start = sa; stop = so; clear = c;
    model_step(r, t, sa, so, c);
    for (int i = 0; i < 3; i++) exp_q.push_back(model_pack(i));
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      n_vec++;
      assert (obs_v[i] === e) else begin
        n_err++;
        $error("FAIL %s dut%0d observed=%h expected=%h", tag, i, obs_v[i], e);
      end
    end
  endtask

  task automatic edges(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, tag);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    end
  endtask

  // Hand-written expectations at the milestones of the plan.
  task automatic check_const(input int i, input logic [17:0] e, input string tag);
    n_vec++;
    assert (obs_v[i] === e) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, i, obs_v[i], e);
    end
  endtask

  initial begin
    rst = 1'b0; tick_in = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    m_tickq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_secs[i] = 0; m_presc[i] = 0; m_ovf[i] = 1'b0; m_state[i] = M_IDLE;
    end
    @(negedge clk);

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    for (int i = 0; i < 3; i++) check_const(i, 18'h0, "reset_const");

    // Edge right after reset, while idle: not counted.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "idle_edge");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_edge");
    check_const(0, 18'h0, "idle_edge_const");

    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "start");
    edges(10, "count10");
    check_const(0, {16'h0010, 1'b1, 1'b0}, "count10_const");

    edges(49, "to_0059");
    check_const(0, {16'h0059, 1'b1, 1'b0}, "at_0059");
    edges(1, "to_0100");
    check_const(0, {16'h0100, 1'b1, 1'b0}, "at_0100");
    edges(539, "to_0959");
    check_const(0, {16'h0959, 1'b1, 1'b0}, "at_0959");
    edges(1, "to_1000");
    check_const(0, {16'h1000, 1'b1, 1'b0}, "at_1000");
    edges(5399, "to_9959");
    check_const(0, {16'h9959, 1'b1, 1'b0}, "at_9959_w1");
    check_const(1, {16'h9959, 1'b1, 1'b0}, "at_9959_w0");
    edges(1, "terminal");
    check_const(0, {16'h0000, 1'b1, 1'b1}, "wrap_ovf");
    check_const(1, {16'h9959, 1'b1, 1'b1}, "sat_ovf");
    edges(3, "post_terminal");
    check_const(1, {16'h9959, 1'b1, 1'b1}, "sat_hold");

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "clear");
    for (int i = 0; i < 3; i++) check_const(i, 18'h0, "clear_const");

    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "start2");
    edges(7, "to_0007");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "stop");
    edges(5, "paused_edges");
    check_const(0, {16'h0007, 1'b0, 1'b0}, "paused_0007");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "resume");
    edges(2, "to_0009");
    check_const(0, {16'h0009, 1'b1, 1'b0}, "resumed_0009");

    // start together with an edge from PAUSE
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "stop2");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "start_edge");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "start_edge");
    check_const(0, {16'h0009, 1'b1, 1'b0}, "start_edge_const");

    // stop together with an edge in RUN
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "stop_edge");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "stop_edge");
    check_const(0, {16'h0009, 1'b0, 1'b0}, "stop_edge_const");

    // clear + start + edge while running
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "start3");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "clear_start_edge");
    check_const(0, 18'h0, "clear_start_edge_const");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "clear_start_edge");

    // rst mid-count with tick_in high
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "start4");
    edges(42, "to_0042");
    check_const(0, {16'h0042, 1'b1, 1'b0}, "at_0042");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rst_mid");
    for (int i = 0; i < 3; i++) check_const(i, 18'h0, "rst_mid_const");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "after_rst");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "after_rst");

    // Prescaler of 4 on dut 2
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "start5");
    edges(10, "presc10");
    check_const(2, {16'h0002, 1'b1, 1'b0}, "presc_0002");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "presc_stop");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "presc_start");
    edges(2, "presc2");
    check_const(2, {16'h0003, 1'b1, 1'b0}, "presc_0003");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
